// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID-side fields in, registered EX-side fields out,
// plus the upstream hold and bubble count.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;

    logic              id_valid;
    logic [DATA_W-1:0] id_pc_plus4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [15:0]       id_imm16;
    logic [DATA_W-1:0] id_imm_sext;
    logic [1:0]        id_imm_mode;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic              id_branch;
    logic [3:0]        id_alu_op;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_alu_src;
    logic              ex_reg_dst;
    logic              ex_branch;
    logic [3:0]        ex_alu_op;

    logic              id_hold;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output stall, flush,
        output id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm16,
               id_imm_sext, id_imm_mode, id_rs, id_rt, id_rd,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_reg_dst, id_branch, id_alu_op,
        input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op,
        input  id_hold, bubble_cnt
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm16,
               id_imm_sext, id_imm_mode, id_rs, id_rt, id_rd,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_reg_dst, id_branch, id_alu_op,
        output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op,
        output id_hold, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate select, load-use interlock and a
// saturating count of the interlock bubbles it inserts.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic              reg_dst;
        logic              branch;
        logic [3:0]        alu_op;
    } ex_t;

    ex_t               ex_q, ex_d, id_pkt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] imm_sel;
    logic              rt_used;
    logic              lu_hazard;

    always_comb begin
        imm_sel = bus.id_imm_sext;
        case (bus.id_imm_mode)
            2'b01:   imm_sel = {{(DATA_W-16){1'b0}}, bus.id_imm16};
            2'b10:   imm_sel = {bus.id_imm16, {(DATA_W-16){1'b0}}};
            default: imm_sel = bus.id_imm_sext;
        endcase
    end

    always_comb begin
        id_pkt            = '0;
        id_pkt.valid      = 1'b1;
        id_pkt.pc_plus4   = bus.id_pc_plus4;
        id_pkt.rs_data    = bus.id_rs_data;
        id_pkt.rt_data    = bus.id_rt_data;
        id_pkt.imm        = imm_sel;
        id_pkt.rs         = bus.id_rs;
        id_pkt.rt         = bus.id_rt;
        id_pkt.rd         = bus.id_rd;
        id_pkt.reg_write  = bus.id_reg_write;
        id_pkt.mem_read   = bus.id_mem_read;
        id_pkt.mem_write  = bus.id_mem_write;
        id_pkt.mem_to_reg = bus.id_mem_to_reg;
        id_pkt.alu_src    = bus.id_alu_src;
        id_pkt.reg_dst    = bus.id_reg_dst;
        id_pkt.branch     = bus.id_branch;
        id_pkt.alu_op     = bus.id_alu_op;
    end

    // rt is a true source operand for R-type ops and for stores (store data).
    assign rt_used   = ~bus.id_alu_src | bus.id_mem_write;
    assign lu_hazard = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & bus.id_valid &
                       ((ex_q.rt == bus.id_rs) | ((ex_q.rt == bus.id_rt) & rt_used));

    assign bus.id_hold = bus.stall | (lu_hazard & ~bus.flush);

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.stall) begin
            ex_d = ex_q;
        end else if (lu_hazard) begin
            ex_d  = '0;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (bus.id_valid) begin
            ex_d = id_pkt;
        end else begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc_plus4   = ex_q.pc_plus4;
    assign bus.ex_rs_data    = ex_q.rs_data;
    assign bus.ex_rt_data    = ex_q.rt_data;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_reg_dst    = ex_q.reg_dst;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.bubble_cnt    = cnt_q;

endmodule
